// File: rtl/jtag_pkg.sv
// Shared JTAG scan-master types: tracked TAP states, field widths and the TAP transition function.
// The transition function is shared so the master can look one edge ahead of the tracker.
package jtag_pkg;

   localparam int LEN_W      = 8;
   localparam int TLR_CYCLES = 5;

   typedef enum logic [2:0] {
      TLR_SEQ,
      IDLE,
      SEL_DR,
      SEL_IR,
      CAPTURE,
      SHIFT,
      EXIT1,
      UPDATE
   } tap_state_t;

   // Pause states are never entered by this master; EXIT1 with TMS=0 falls back into SHIFT.
   function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
      tap_state_t n;
      case (s)
         TLR_SEQ: n = tms ? TLR_SEQ : IDLE;
         IDLE:    n = tms ? SEL_DR  : IDLE;
         SEL_DR:  n = tms ? SEL_IR  : CAPTURE;
         SEL_IR:  n = tms ? TLR_SEQ : CAPTURE;
         CAPTURE: n = tms ? EXIT1   : SHIFT;
         SHIFT:   n = tms ? EXIT1   : SHIFT;
         EXIT1:   n = tms ? UPDATE  : SHIFT;
         UPDATE:  n = tms ? SEL_DR  : IDLE;
         default: n = TLR_SEQ;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// Mirror of the target TAP controller, advanced by the TMS value the target samples each edge.
// One edge of latency from TMS to state; no backpressure.
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic       TCLK,
   input  logic       TRST,
   input  logic       TMS,
   output tap_state_t state
);

   tap_state_t state_d;

   always_comb begin
      state_d = tap_next(state, TMS);
   end

   always_ff @(posedge TCLK or negedge TRST) begin
      if (!TRST) begin
         state <= TLR_SEQ;
      end else begin
         state <= state_d;
      end
   end

endmodule

// File: rtl/jtag_scan_master.sv
// JTAG scan master: TLR reset sequence, then IR/DR scans of 0..255 bits; TDO capture under JTAG_TDO_CAPTURE_EN.
// Scan of N bits takes N+5 edges (N+6 for IR); din is never waited on -- a missing bit shifts 0 and sets underrun.
module jtag_scan_master
   import jtag_pkg::*;
(
   input  logic             TCLK,
   input  logic             TRST,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_ir,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             done,
   output logic             underrun,
   output logic             TMS,
   output logic             TDI,
   input  logic             TDO
);

   tap_state_t       state;
   tap_state_t       state_nxt;
   logic [LEN_W-1:0] cnt;
   logic [2:0]       tlr_cnt;
   logic             busy;
   logic             ir;
   logic             zero_pend;
   logic             accept;
   logic             done_d;
   logic             tms_d;

   jtag_tap_fsm u_tap (
      .TCLK  (TCLK),
      .TRST  (TRST),
      .TMS   (TMS),
      .state (state)
   );

   // TMS is registered, so the value chosen now is sampled by the target on the following edge,
   // when it will already be in state_nxt.
   assign state_nxt = tap_next(state, TMS);
   assign cmd_ready = (state == IDLE) && !busy;
   assign accept    = cmd_valid && cmd_ready;
   assign din_ready = (state_nxt == SHIFT);
   assign done_d    = ((state == UPDATE) && (state_nxt == IDLE)) || zero_pend;

   always_comb begin
      tms_d = 1'b0;
      case (state_nxt)
         TLR_SEQ: tms_d = (tlr_cnt != 3'(TLR_CYCLES - 1));
         IDLE:    tms_d = accept && (cmd_len != '0);
         SEL_DR:  tms_d = ir;
         SHIFT:   tms_d = (cnt == LEN_W'(1));
         EXIT1:   tms_d = 1'b1;
         default: tms_d = 1'b0;
      endcase
   end

   always_ff @(posedge TCLK or negedge TRST) begin
      if (!TRST) begin
         TMS       <= 1'b1;
         TDI       <= 1'b0;
         cnt       <= '0;
         tlr_cnt   <= '0;
         busy      <= 1'b0;
         ir        <= 1'b0;
         zero_pend <= 1'b0;
         done      <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         TMS       <= tms_d;
         tlr_cnt   <= ((state == TLR_SEQ) && TMS) ? tlr_cnt + 3'd1 : 3'd0;
         zero_pend <= accept && (cmd_len == '0);
         done      <= done_d;
         if (accept) begin
            busy     <= 1'b1;
            ir       <= cmd_ir;
            cnt      <= cmd_len;
            underrun <= 1'b0;
         end else if (done_d) begin
            busy <= 1'b0;
         end
         // Each consumed bit lands on TDI one edge before the target shifts it.
         if (din_ready) begin
            TDI <= din_valid & din;
            if (!din_valid) begin
               underrun <= 1'b1;
            end
            if (cnt != '0) begin
               cnt <= cnt - LEN_W'(1);
            end
         end else begin
            TDI <= 1'b0;
         end
      end
   end

`ifdef JTAG_TDO_CAPTURE_EN
   always_ff @(posedge TCLK or negedge TRST) begin
      if (!TRST) begin
         dout       <= 1'b0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= (state == SHIFT);
         dout       <= (state == SHIFT) ? TDO : 1'b0;
      end
   end
`else
   logic tdo_unused;
   assign tdo_unused = TDO;
   assign dout       = 1'b0;
   assign dout_valid = 1'b0;
`endif

endmodule

// File: doc/jtag_scan_master.md
JTAG_SCAN_MASTER -- requirements
Module: jtag_scan_master

Interface
REQ-001 SHALL use one clock, TCLK, and an asynchronous, active-low reset, TRST.
REQ-002 TCLK  input  1  scan clock; all state and outputs update on its rising edge.
REQ-003 TRST  input  1  asynchronous active-low reset.
REQ-004 cmd_valid  input  1  scan command offered.
REQ-005 cmd_ready  output  1  master in Run-Test/Idle and able to accept a command.
REQ-006 cmd_ir  input  1  1 = IR scan, 0 = DR scan.
REQ-007 cmd_len  input  8  scan length in bits, 0..255.
REQ-008 din, din_valid  input  1 each  TDI bit stream, LSB-first.
REQ-009 din_ready  output  1  din consumed on this edge.
REQ-010 dout, dout_valid  output  1 each  captured TDO bit stream, LSB-first.
REQ-011 done  output  1  one-cycle pulse when a scan has completed.
REQ-012 underrun  output  1  sticky flag: din was missing during a shift.
REQ-013 TMS, TDI  output  1 each  registered drives to the target TAP.
REQ-014 TDO  input  1  serial data from the target TAP.

Function
REQ-015 SHALL track the target TAP in these states: TLR_SEQ, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE.
REQ-016 After reset, TLR_SEQ SHALL drive TMS=1 for 5 edges and then TMS=0 for 1 edge, then enter IDLE.
REQ-017 In IDLE, cmd_ready=1 and TMS=0; a command is accepted on an edge where cmd_valid and cmd_ready are both 1.
REQ-018 DR scan TMS sequence: 1 (SEL_DR), 0 (CAPTURE), 0 (SHIFT), then cmd_len-1 zeros, then 1 (EXIT1), 1 (UPDATE), 0 (IDLE); total cmd_len+5 edges.
REQ-019 IR scan SHALL insert one extra TMS=1 edge (SEL_IR) after SEL_DR; total cmd_len+6 edges.
REQ-020 Bit i SHALL be presented on TDI for the edge on which the target shifts bit i, with din_ready=1 one edge before.
REQ-021 If din_valid=0 when a bit is required, SHALL drive TDI=0, set underrun, and continue without stalling.
REQ-022 TDO SHALL be sampled on each shift edge; dout_valid SHALL pulse with the sampled bit exactly cmd_len times.
REQ-023 done SHALL pulse on the edge entering IDLE; cmd_ready SHALL reassert on that same edge.
REQ-024 cmd_len=0 SHALL be accepted with no TAP movement; done SHALL pulse on the next edge.
REQ-025 underrun SHALL clear only when the next command is accepted.
REQ-026 The shift counter SHALL be 8 bits, count down from cmd_len, and never wrap.

Reset
REQ-027 While TRST=0: TMS=1, TDI=0, cmd_ready=0, din_ready=0, dout_valid=0, done=0, underrun=0, state=TLR_SEQ, counter=0.
REQ-028 TRST asserted mid-scan SHALL abort the scan immediately with no done pulse; the full TLR_SEQ SHALL rerun on release.

Configuration
REQ-029 Macro JTAG_TDO_CAPTURE_EN: when defined, implements REQ-022.
REQ-030 When JTAG_TDO_CAPTURE_EN is undefined, dout and dout_valid SHALL be tied to 0, TDO SHALL be unused, and TMS/TDI timing SHALL be unchanged.

Structure
REQ-031 Shared package jtag_pkg SHALL hold the state enum, LEN_W=8 and TLR_CYCLES=5.
REQ-032 TAP state tracking SHALL be a sub-module jtag_tap_fsm (inputs: TMS; output: state); the master SHALL own the sequencing, counters and datapath.

Verification
REQ-033 Reset release -> TMS = 1,1,1,1,1,0; cmd_ready rises on the 6th edge after TRST=1.
REQ-034 IR scan, len=2, din 1 then 0 -> TMS = 1,1,0,0,0,1,1,0; TDI=1 then 0 on the shift edges; done on the 8th edge.
REQ-035 DR scan, len=36, all-zero din, TDO driven 36'hA5A5A5A5A -> dout stream LSB-first equals 36'hA5A5A5A5A; done on edge 41.
REQ-036 DR scan, len=8, din_valid low for bit 5 -> bit-5 TDI=0, underrun=1, done still on edge 13; underrun clears on next accept.
REQ-037 TRST low during SHIFT -> TMS=1 same cycle, no done, no further dout_valid; 6-edge TLR_SEQ reruns on release.
REQ-038 cmd_len=0 -> done on the next edge, TMS stays 0, no din_ready, no dout_valid.
